// File: rtl/bch31_encoder_if.sv
// Streaming handshake bundle for the BCH(31,21) encoder: message bits in, codeword bits out.
// The slave modport is the encoder's view and the master modport is the driver/sink view.
interface bch31_encoder_if;
    logic in_valid;
    logic in_ready;
    logic in_data;
    logic out_valid;
    logic out_ready;
    logic out_data;
    logic out_first;
    logic out_last;
    logic busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_first,
        output out_last,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_first,
        input  out_last,
        input  busy
    );
endinterface

// File: rtl/bch31_encoder.sv
// Systematic serial BCH(31,21) encoder: the 21 message bits pass straight through,
// then the 10 parity bits held in the division LFSR over g(x) are shifted out MSB first.
module bch31_encoder #(
    parameter int          N        = 31,
    parameter int          K        = 21,
    parameter logic [10:0] GEN_POLY = 11'h769
) (
    input  logic           clk,
    input  logic           rst,
    bch31_encoder_if.slave bus
);
    localparam int         P        = N - K;
    localparam logic [4:0] LAST_MSG = 5'(K - 1);
    localparam logic [4:0] LAST_BIT = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    state_t         state_reg;
    logic [4:0]     cnt_reg;
    logic [P-1:0]   par_reg;
    logic [P-1:0]   par_next;
    logic [P-1:0]   par_shift;
    logic           fb;

    // One division step: shift left and fold in g(x) when the feedback bit is set.
    assign fb        = bus.in_data ^ par_reg[P-1];
    assign par_shift = {par_reg[P-2:0], 1'b0};

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_lfsr
            if (gi == 0) begin : g_lsb
                assign par_next[gi] = fb & GEN_POLY[gi];
            end else begin : g_upper
                assign par_next[gi] = par_reg[gi-1] ^ (fb & GEN_POLY[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            par_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg <= MSG;
                end
                MSG: begin
                    if (bus.in_valid && bus.out_ready) begin
                        par_reg <= par_next;
                        cnt_reg <= cnt_reg + 5'd1;
                        if (cnt_reg == LAST_MSG) begin
                            state_reg <= PAR;
                        end
                    end
                end
                PAR: begin
                    if (bus.out_ready) begin
                        if (cnt_reg == LAST_BIT) begin
                            cnt_reg   <= '0;
                            par_reg   <= '0;
                            state_reg <= MSG;
                        end else begin
                            cnt_reg <= cnt_reg + 5'd1;
                            par_reg <= par_shift;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Message phase is a zero-latency pass-through, so the outputs decode state combinationally.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 1'b0;
        bus.out_first = 1'b0;
        bus.out_last  = 1'b0;
        case (state_reg)
            MSG: begin
                bus.in_ready  = bus.out_ready;
                bus.out_valid = bus.in_valid;
                bus.out_data  = bus.in_data;
                bus.out_first = (cnt_reg == 5'd0) && bus.in_valid;
            end
            PAR: begin
                bus.out_valid = 1'b1;
                bus.out_data  = par_reg[P-1];
                bus.out_last  = (cnt_reg == LAST_BIT);
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

    assign bus.busy = (cnt_reg != 5'd0);
endmodule

// File: tb/tb_bch31_encoder.sv
// Directed plus randomized bench for bch31_encoder; expected codewords come from
// polynomial long division of m(x)*x^10 by g(x).
module tb_bch31_encoder;
    localparam int          N = 31;
    localparam int          K = 21;
    localparam logic [10:0] G = 11'h769;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bch31_encoder_if bus();

    bch31_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [9:0] ref_parity(input logic [20:0] m);
        logic [30:0] r;
        logic [30:0] g_full;
        r      = {m, 10'b0};
        g_full = {20'b0, G};
        for (int i = 30; i >= 10; i--) begin
            if (r[i]) r = r ^ (g_full << (i - 10));
        end
        return r[9:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        check({tag, "_out_first"}, 32'(bus.out_first), 32'd0);
        check({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    // Streams one codeword (or the first stop_after bits of it) and checks every cycle.
    task automatic run_cw(input logic [20:0] m, input bit stall, input int stop_after,
                          output logic [30:0] got);
        logic [30:0] exp;
        int          idx;
        int          budget;
        bit          vld;
        bit          rdy;
        bit          ev;
        exp    = {m, ref_parity(m)};
        got    = '0;
        idx    = 0;
        budget = 0;
        vld    = stall ? 1'($urandom_range(1)) : 1'b1;
        while (idx < stop_after && budget < 400) begin
            @(negedge clk);
            budget++;
            if (!vld) vld = stall ? 1'($urandom_range(1)) : 1'b1;
            rdy = stall ? 1'($urandom_range(1)) : 1'b1;
            if (idx < K) begin
                bus.in_valid = vld;
                bus.in_data  = m[20-idx];
                ev           = vld;
            end else begin
                bus.in_valid = 1'($urandom_range(1));
                bus.in_data  = 1'($urandom_range(1));
                ev           = 1'b1;
            end
            bus.out_ready = rdy;
            #1;
            if (idx < K) check("msg_in_ready", 32'(bus.in_ready), 32'(rdy));
            else         check("par_in_ready", 32'(bus.in_ready), 32'd0);
            check("out_valid", 32'(bus.out_valid), 32'(ev));
            if (ev) check("out_data", 32'(bus.out_data), 32'(exp[30-idx]));
            check("out_first", 32'(bus.out_first), 32'((idx == 0) && ev));
            check("out_last",  32'(bus.out_last),  32'(idx == N - 1));
            check("busy",      32'(bus.busy),      32'(idx != 0));
            if (ev && rdy) begin
                got[30-idx] = bus.out_data;
                if (idx == 0)     first_cyc = cyc;
                if (idx == N - 1) last_cyc  = cyc;
                idx++;
                vld = stall ? 1'($urandom_range(1)) : 1'b1;
            end
        end
        check("transfers_done", 32'(idx), 32'(stop_after));
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        logic [30:0] got;
        logic [20:0] m;
        int          prev_last;

        bus.in_valid  = 1'b1;
        bus.in_data   = 1'b1;
        bus.out_ready = 1'b1;

        // Held in reset with upstream/downstream active: everything must read zero.
        @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("idle");

        run_cw(21'h0, 1'b0, N, got);
        check("cw_zero", 32'(got), 32'd0);

        run_cw(21'h1, 1'b0, N, got);
        check("cw_m1", 32'(got), 32'h769);
        prev_last = last_cyc;

        run_cw(21'h1FFFFF, 1'b0, N, got);
        check("cw_ones", 32'(got), 32'h7FFFFFFF);
        check("b2b_gap", 32'(first_cyc - prev_last), 32'd1);

        for (int t = 0; t < 6; t++) begin
            m = 21'($urandom);
            run_cw(m, 1'b1, N, got);
            check("cw_rand_stall", 32'(got), 32'({m, ref_parity(m)}));
        end

        run_cw(21'h1, 1'b1, N, got);
        check("cw_m1_stall", 32'(got), 32'h769);

        // Abandon a codeword after the third parity bit.
        m = 21'($urandom);
        run_cw(m, 1'b0, K + 3, got);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("midreset_idle");
        run_cw(21'h1, 1'b0, N, got);
        check("cw_after_reset", 32'(got), 32'h769);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
